fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage feeding the decode/execute pipeline. Owns the PC and issues
//   in-order requests to instruction memory. Buffers returned words in a small prefetch queue
//   and hands one instruction per cycle downstream.
//   Redirects on the branch resolution (flag + target) produced by the execute stage.
// PARAMETERS
//   QUEUE_DEPTH      4        prefetch queue entries (power of 2, >=2)
//   MAX_OUTSTANDING  4        max imem requests in flight (<= QUEUE_DEPTH)
//   RESET_PC         16'h0000 PC loaded on reset
// PORTS
//   clk              in   1   clock; all state updates on posedge
//   rst              in   1   reset, synchronous, active-high
//   branch_flag      in   1   execute resolved a branch this cycle (fetch_branch_flag)
//   branch_target    in   16  new PC when branch_flag=1 (fetch_program_counter)
//   stall            in   1   downstream cannot accept a new instruction this cycle
//   imem_req_valid   out  1   request valid
//   imem_req_ready   in   1   memory accepts request (handshake = valid & ready)
//   imem_req_addr    out  16  word address requested
//   imem_resp_valid  in   1   response word valid; in order, >=1 cycle after accept, no backpressure
//   imem_resp_data   in   16  instruction word
//   out_valid        out  1   out_insn/out_pc carry a real instruction
//   out_insn         out  16  instruction to execute; 16'h0000 (NOP) whenever out_valid=0
//   out_pc           out  16  address of out_insn
// BEHAVIOUR
//   Reset: pc=RESET_PC, queue empty, inflight=0, drop=0; imem_req_valid=0, out_valid=0,
//     out_insn=16'h0000, out_pc=16'h0000. Reset mid-transfer abandons all in-flight responses
//     without tracking them; the memory is reset with this block.
//   Issue: imem_req_valid=1 iff !rst & (q_count + inflight - drop) < QUEUE_DEPTH
//     & inflight < MAX_OUTSTANDING. imem_req_addr=pc.
//     On accept: pc<=pc+1 (16-bit wrap, FFFF->0000) and inflight+1.
//   Response: inflight-1. If drop>0, discard word and drop-1, else push {word, addr} into queue.
//     The address comes from a resp-pc counter advanced per kept word.
//     Queue can never overflow by construction; overflow is an assertion failure.
//   Output register: when !stall, pop head into out_* with out_valid=1 if the queue is nonempty;
//     otherwise out_valid=0 and out_insn=16'h0000. Push and pop in the same cycle are legal;
//     an empty queue does not bypass, so there is 1 cycle of latency from resp to queue head.
//     When stall=1, out_* hold.
//   Redirect (branch_flag=1, highest priority, overrides stall):
//     - pc<=branch_target; resp-pc<=branch_target.
//     - Flush the queue. out_valid<=0, out_insn<=16'h0000.
//     - drop<=inflight-after-this-cycle minus responses discarded this cycle. A response arriving
//       in the redirect cycle is discarded. A request accepted in the redirect cycle is
//       suppressed: imem_req_valid=0 that cycle.
//     - Requests resume the following cycle at the target.
//     - Back-to-back redirects: the last one wins, and drop accumulates correctly.
//   Minimum branch penalty: redirect cycle + memory latency + 1 queue cycle.
//   Widths: q_count up to QUEUE_DEPTH. inflight/drop are clog2(MAX_OUTSTANDING+1) bits.
//   No arithmetic beyond +1.
// STRUCTURE
//   cpu_pkg: localparam NOP=16'h0000; insn class codes (ALU=2'b00, BR=2'b01, LD=2'b10,
//     ST=2'b11); INSN_W=16, ADDR_W=16.
//   Sub-module fetch_queue: sync FIFO {insn, pc}, with push, pop, flush, count, empty, full.
//     flush has priority over push.
//   Top level holds pc, resp-pc, inflight/drop counters, issue logic and the output register.
// TESTING
//   1 Reset, imem latency 1, always ready -> requests 0000,0001,...; first out_valid on cycle 3;
//     then one insn per cycle with out_pc sequential.
//   2 stall held high 6 cycles -> at most QUEUE_DEPTH kept + out_reg held; req_valid drops once
//     q_count+inflight=4; no word lost or duplicated after release.
//   3 Latency 3, branch_flag with target 0x0040 while 3 requests in flight -> 3 responses
//     discarded; next out_insn is word @0x0040 with out_pc=0x0040.
//   4 branch_flag in the same cycle as imem_resp_valid and stall=1 -> resp dropped; out_valid=0;
//     no request issued that cycle.
//   5 Two redirects on consecutive cycles (0x0100 then 0x0200) -> only 0x0200 stream emerges.
//   6 pc=0xFFFE, no branches -> addresses FFFE, FFFF, 0000; out_pc wraps identically.
//     rst pulsed mid-stream -> outputs return to reset values on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, the NOP encoding, instruction class codes and
//               the prefetch queue entry layout for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSN_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [INSN_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ALU = 2'b00,
        BR  = 2'b01,
        LD  = 2'b10,
        ST  = 2'b11
    } insn_class_e;

    // One prefetched instruction together with the address it was read from.
    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Sequential next address; wraps FFFF -> 0000.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the fetch stage's instruction-memory handshake, the
//               redirect/stall controls and the downstream instruction slot.
//               master = fetch unit side, slave = memory/pipeline side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import cpu_pkg::*;

    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target;
    logic              stall;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [INSN_W-1:0] imem_resp_data;
    logic              out_valid;
    logic [INSN_W-1:0] out_insn;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        input  branch_flag, branch_target, stall,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output imem_req_valid, imem_req_addr,
        output out_valid, out_insn, out_pc
    );

    modport slave (
        output branch_flag, branch_target, stall,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_insn, out_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous prefetch FIFO of {insn, pc} entries. Push and pop
//               may coincide; flush empties the queue and wins over push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  fetch_entry_t                 i_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_pop_eff;
    logic                 w_push_eff;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == c_CNT_W'(DEPTH));
    assign o_count    = r_count;
    assign o_head     = r_mem[r_rd_ptr];
    assign w_pop_eff  = i_pop & ~o_empty;
    assign w_push_eff = i_push & (~o_full | w_pop_eff);

    // Pointer and occupancy bookkeeping; flush behaves like a reset.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_eff) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop_eff)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push_eff, w_pop_eff})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Entry storage; data path only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push_eff && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    // The issue logic upstream must never let the queue overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_flush && o_full && !w_pop_eff));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, issues in-order imem
//               requests, buffers returned words in a prefetch queue and
//               presents one instruction per cycle. Branch redirects flush
//               the queue and discard every response still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                QUEUE_DEPTH     = 4,
    parameter int                MAX_OUTSTANDING = 4,
    parameter logic [ADDR_W-1:0] RESET_PC        = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int c_CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_QCNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int c_OCC_W  = ((c_QCNT_W > c_CNT_W) ? c_QCNT_W : c_CNT_W) + 1;

    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_resp_pc;
    logic [c_CNT_W-1:0]  r_inflight;
    logic [c_CNT_W-1:0]  r_drop;
    logic                r_out_valid;
    logic [INSN_W-1:0]   r_out_insn;
    logic [ADDR_W-1:0]   r_out_pc;

    logic [c_CNT_W-1:0]  w_inflight_next;
    logic [c_OCC_W-1:0]  w_occ;
    logic                w_req_valid;
    logic                w_accept;
    logic                w_resp;
    logic                w_push;
    logic                w_pop;
    fetch_entry_t        w_push_data;
    fetch_entry_t        w_head;
    logic [c_QCNT_W-1:0] w_q_count;
    logic                w_q_empty;
    logic                w_q_full;

    // Words that will eventually occupy the queue: already queued plus the
    // in-flight ones that will be kept. Responses slated for dropping never
    // take a slot.
    assign w_occ = c_OCC_W'(w_q_count) + c_OCC_W'(r_inflight) - c_OCC_W'(r_drop);

    // A request in a redirect cycle would target the stale path, so it is held off.
    assign w_req_valid = !rst && !bus.branch_flag
                      && (w_occ < c_OCC_W'(QUEUE_DEPTH))
                      && (r_inflight < c_CNT_W'(MAX_OUTSTANDING));

    assign w_accept    = w_req_valid & bus.imem_req_ready;
    assign w_resp      = bus.imem_resp_valid;
    assign w_push      = w_resp & ~bus.branch_flag & (r_drop == '0);
    assign w_pop       = ~bus.branch_flag & ~bus.stall & ~w_q_empty;
    assign w_push_data = '{insn: bus.imem_resp_data, pc: r_resp_pc};

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_insn       = r_out_insn;
    assign bus.out_pc         = r_out_pc;

    // Outstanding-request count after this cycle's accept and response.
    always_comb begin
        w_inflight_next = r_inflight;
        case ({w_accept, w_resp})
            2'b10:   w_inflight_next = r_inflight + c_CNT_W'(1);
            2'b01:   w_inflight_next = r_inflight - c_CNT_W'(1);
            default: ;
        endcase
    end

    // PC, response-PC and in-flight/drop accounting; redirect overrides all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (bus.branch_flag) begin
                // Everything still outstanding belongs to the old path; a
                // response arriving now is discarded outright.
                r_pc      <= bus.branch_target;
                r_resp_pc <= bus.branch_target;
                r_drop    <= w_inflight_next;
            end else begin
                if (w_accept) r_pc <= pc_inc(r_pc);
                if (w_resp) begin
                    if (r_drop != '0) r_drop    <= r_drop - c_CNT_W'(1);
                    else              r_resp_pc <= pc_inc(r_resp_pc);
                end
            end
        end
    end

    // Output register: redirect clears it, stall holds it, otherwise pop the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_insn  <= NOP;
            r_out_pc    <= '0;
        end else if (bus.branch_flag) begin
            r_out_valid <= 1'b0;
            r_out_insn  <= NOP;
        end else if (!bus.stall) begin
            r_out_valid <= ~w_q_empty;
            r_out_insn  <= w_q_empty ? NOP : w_head.insn;
            if (!w_q_empty) r_out_pc <= w_head.pc;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (bus.branch_flag),
        .o_head  (w_head),
        .o_count (w_q_count),
        .o_empty (w_q_empty),
        .o_full  (w_q_full)
    );

    // A full queue means the occupancy budget is spent, so issue must be off.
    a_full_blocks_issue: assert property (@(posedge clk) disable iff (rst)
        w_q_full |-> !w_req_valid);

endmodule
`default_nettype wire
